instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly downstream of the program counter and upstream of the decoder. It reads the current PC, issues one instruction-memory read at a time, and buffers returned instructions with their PCs in a 2-entry queue. It drives the counter's `load`/`load_val` port to hold the PC while fetch is stalled and to redirect it on branches. The counter only advances in the cycle a memory request is granted.

## Interface
- `ADDR_W`, 26, PC / memory word-address width (matches counter)
- `DATA_W`, 32, instruction width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `pc`  in  ADDR_W  current PC, from counter `count`
- `pc_load`  out  1  to counter `load`; combinational
- `pc_load_val`  out  ADDR_W  to counter `load_val`; combinational
- `mem_req`  out  1  read request valid
- `mem_addr`  out  ADDR_W  read address; equals `pc` while `mem_req`=1
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid; exactly one per granted request, ≥1 cycle after grant
- `mem_rdata`  in  DATA_W  read data
- `redirect`  in  1  flush and jump, from execute
- `redirect_pc`  in  ADDR_W  jump target
- `instr_valid`  out  1  queue head valid
- `instr_ready`  in  1  decoder accepts head
- `instr`  out  DATA_W  head instruction
- `instr_pc`  out  ADDR_W  PC of head instruction

## Operation
- FSM states:
  - `REQ`: `mem_req`=1. On `mem_gnt`, latch `pc` into `req_pc` and go to `WAIT`.
  - `WAIT`: wait for `mem_rvalid`; push `{req_pc, mem_rdata}` into the queue.
  - `FULL`: queue full; no request.
  - `DRAIN`: discard one in-flight response.
- `WAIT` + `mem_rvalid`: go to `REQ` if post-update occupancy < 2, else `FULL`.
- `FULL` → `REQ` once occupancy < 2.
- PC control, in priority order:
  - `redirect`=1: `pc_load`=1, `pc_load_val`=`redirect_pc`.
  - Else `REQ` with `mem_gnt`=1: `pc_load`=0, so the counter increments.
  - Else: `pc_load`=1, `pc_load_val`=`pc`, so the counter holds.
  - During `reset`: `pc_load`=0.
- Queue: 2-entry FIFO.
  - `instr_valid` = occupancy ≠ 0.
  - Pop on `instr_valid && instr_ready`.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- `redirect` behaviour:
  - Queue is cleared next cycle. A pop handshake in the redirect cycle is void.
  - In `WAIT` without `mem_rvalid` the next state is `DRAIN`; otherwise `REQ`.
  - In `REQ` with `mem_gnt` the next state is `DRAIN`, because the granted request's response must be dropped.
  - `mem_rvalid` arriving in the redirect cycle is discarded.
- `DRAIN`: on `mem_rvalid`, discard the data and go to `REQ`. A further `redirect` in `DRAIN` stays in `DRAIN`.
- Only one request is outstanding at any time. `mem_req` is never asserted in `WAIT`, `FULL` or `DRAIN`.

## Timing
- Reset values: state `REQ`; occupancy 0; `mem_req`=1 from the first cycle after reset. During reset: `mem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `pc_load`=0.
- Latency, with grant in cycle N and `mem_rvalid` in N+1: `instr_valid`=1 in N+2. First instruction after reset: PC 0, valid 2 cycles after reset deassertion.
- Peak throughput: 1 instruction per 2 cycles.
- Redirect in cycle N:
  - Counter holds `redirect_pc` in N+1.
  - Queue is empty in N+1.
  - If no drain is needed, a request for `redirect_pc` is issued in N+1.
- Queue outputs are registered; `instr_valid` never depends combinationally on `instr_ready`.

## Configuration
- `FETCH_BYPASS_EN` defined: when the queue is empty and `mem_rvalid`=1 in `WAIT` without `redirect`:
  - `instr_valid`/`instr`/`instr_pc` present `mem_rdata`/`req_pc` combinationally in the same cycle.
  - If `instr_ready`=1 in that cycle, the entry is not pushed.
  - Latency drops to 1 cycle after grant.
- Not defined: all instructions pass through the queue; latency is as stated in Timing.

## Test plan
- Reset, then `mem_gnt`=1 every `REQ` cycle, rvalid 1 cycle later, data = 0xA000_0000+addr, `instr_ready`=1 → instructions for PCs 0,1,2,3 in order, every other cycle starting 2 cycles after reset deassertion; `pc_load`=0 exactly in grant cycles.
- `instr_ready`=0 → two entries buffered (PCs 0,1); state `FULL`; `mem_req`=0; counter holds at 2 (`pc_load`=1, `pc_load_val`=2); releasing ready resumes fetch at PC 2.
- `mem_gnt` held low 5 cycles → `mem_addr` stable at the current PC; `pc_load_val`=`pc` each cycle; no increment.
- `redirect`=1 with `redirect_pc`=0x100 while in `WAIT` → stale rvalid discarded (`DRAIN`); queue empty; next request address 0x100; next `instr_pc`=0x100.
- `redirect` coincident with `mem_rvalid` and a pop → data dropped; occupancy 0 next cycle; next request 0x100.
- `FETCH_BYPASS_EN` defined, empty queue, rvalid with `instr_ready`=1 → `instr_valid`=1 in the same cycle; occupancy stays 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding read, 2-entry instruction queue, and PC hold/redirect control.
// Define FETCH_BYPASS_EN to present a response straight to the decoder when the queue is empty.
module instr_fetch #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] pc_load_val_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o
);

  typedef enum logic [1:0] {StReq, StWait, StFull, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] qi_q [2];
  logic [DATA_W-1:0] qi_d [2];
  logic [ADDR_W-1:0] qp_q [2];
  logic [ADDR_W-1:0] qp_d [2];
  logic              rsp, push, pop, bypass;
  logic [1:0]        wr_slot;

  assign rsp = (state_q == StWait) && mem_rvalid_i && !redirect_i;
`ifdef FETCH_BYPASS_EN
  assign bypass = rsp && (count_q == 2'd0);
`else
  assign bypass = 1'b0;
`endif
  // A pop handshake in a redirect cycle is void; the queue is flushed instead.
  assign pop     = (count_q != 2'd0) && instr_ready_i && !redirect_i;
  assign push    = rsp && !(bypass && instr_ready_i);
  assign wr_slot = count_q - {1'b0, pop};

  assign mem_addr_o = pc_i;

  always_comb begin
    count_d = count_q;
    qi_d    = qi_q;
    qp_d    = qp_q;
    if (redirect_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        qi_d[0] = qi_q[1];
        qp_d[0] = qp_q[1];
      end
      if (push) begin
        qi_d[wr_slot[0]] = mem_rdata_i;
        qp_d[wr_slot[0]] = req_pc_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StReq;
      req_pc_q <= '0;
      count_q  <= 2'd0;
      qi_q     <= '{default: '0};
      qp_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      qi_q     <= qi_d;
      qp_q     <= qp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      StReq: begin
        if (mem_gnt_i) begin
          req_pc_d = pc_i;
          // A request granted alongside a redirect fetches a stale PC; its response is dropped.
          state_d  = redirect_i ? StDrain : StWait;
        end
      end
      StWait: begin
        if (redirect_i) begin
          state_d = mem_rvalid_i ? StReq : StDrain;
        end else if (mem_rvalid_i) begin
          state_d = (count_d == 2'd2) ? StFull : StReq;
        end
      end
      StFull: begin
        if (count_d != 2'd2) state_d = StReq;
      end
      StDrain: begin
        if (mem_rvalid_i) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    mem_req_o     = !reset && (state_q == StReq);
    pc_load_o     = 1'b0;
    pc_load_val_o = pc_i;
    if (!reset) begin
      if (redirect_i) begin
        pc_load_o     = 1'b1;
        pc_load_val_o = redirect_pc_i;
      end else if (!((state_q == StReq) && mem_gnt_i)) begin
        pc_load_o = 1'b1;
      end
    end
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (!reset) begin
      if (count_q != 2'd0) begin
        instr_valid_o = 1'b1;
        instr_o       = qi_q[0];
        instr_pc_o    = qp_q[0];
      end else if (bypass) begin
        instr_valid_o = 1'b1;
        instr_o       = mem_rdata_i;
        instr_pc_o    = req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing steps, then random traffic checked against an
// architectural model (sequential PC stream restarting at each redirect target).
module tb_instr_fetch;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 32;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk, reset;
  logic [ADDR_W-1:0] pc, pc_load_val, mem_addr, redirect_pc, instr_pc;
  logic              pc_load, mem_req, mem_gnt, mem_rvalid, redirect, instr_valid, instr_ready;
  logic [DATA_W-1:0] mem_rdata, instr;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned n_acc    = 0;
  logic [ADDR_W-1:0] exp_pc, pc_next, out_addr;
  logic              out_valid;
  int                out_age;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .pc_i(pc), .pc_load_o(pc_load), .pc_load_val_o(pc_load_val),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .instr_o(instr),
    .instr_pc_o(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Memory answers an outstanding request at least one cycle after its grant.
  task automatic drive(input logic gnt, input logic rv_ok, input logic rdy, input logic redir,
                       input logic [ADDR_W-1:0] rpc);
    mem_gnt     = gnt;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    mem_rvalid  = out_valid && (out_age >= 1) && rv_ok;
    mem_rdata   = mem_rvalid ? mem_word(out_addr) : 32'hDEAD_BEEF;
    #3;
  endtask

  task automatic observe();
    if (reset) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_pc_load", pc_load, 0);
      pc_next   = '0;
      out_valid = 1'b0;
      exp_pc    = '0;
    end else begin
      if (mem_req) begin
        check("mem_addr_eq_pc", mem_addr, pc);
        check("one_outstanding", out_valid, 0);
      end
      check("pc_load", pc_load, redirect || !(mem_req && mem_gnt));
      if (pc_load) check("pc_load_val", pc_load_val, redirect ? redirect_pc : pc);
      if (instr_valid && instr_ready && !redirect) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr_data", instr, mem_word(exp_pc));
        exp_pc++;
        n_acc++;
      end
      if (redirect) exp_pc = redirect_pc;
      if (mem_rvalid) out_valid = 1'b0;
      if (mem_req && mem_gnt) begin
        out_valid = 1'b1;
        out_addr  = pc;
        out_age   = 0;
      end
      pc_next = pc_load ? pc_load_val : pc + ADDR_W'(1);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    pc = pc_next;
    if (out_valid) out_age++;
  endtask

  task automatic cyc(input logic gnt, input logic rv_ok, input logic rdy, input logic redir,
                     input logic [ADDR_W-1:0] rpc);
    drive(gnt, rv_ok, rdy, redir, rpc);
    observe();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    reset = 1'b0;
  endtask

  task automatic wait_first_pc(input string tag, input logic [ADDR_W-1:0] want);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
      if (instr_valid) begin
        seen = 1;
        check(tag, instr_pc, want);
      end
      observe();
      advance();
    end
    check({tag, "_timeout"}, seen, 1);
  endtask

  initial begin
    int unsigned acc_before;
    reset = 1'b1; pc = '0; out_valid = 1'b0; out_age = 0; out_addr = '0; exp_pc = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; redirect = 0; redirect_pc = '0; instr_ready = 0;
    @(posedge clk);
    #1;

    // Streaming fetch: grant every request, immediate response, decoder always ready.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("t1_mem_req", mem_req, (c % 2) == 0);
      check("t1_pc_load", pc_load, (c % 2) != 0);
      check("t1_instr_valid", instr_valid, (c >= LAT) && ((c - LAT) % 2 == 0));
      if ((c >= LAT) && ((c - LAT) % 2 == 0)) check("t1_instr_pc", instr_pc, (c - LAT) / 2);
      observe();
      advance();
    end

    // Decoder stalled: queue fills with PCs 0 and 1, counter holds at 2.
    do_reset();
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("t2_mem_req", mem_req, 0);
      check("t2_instr_valid", instr_valid, 1);
      check("t2_head_pc", instr_pc, 0);
      check("t2_pc_load", pc_load, 1);
      check("t2_pc_hold", pc_load_val, 2);
      observe();
      advance();
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);
    // Grant withheld: request stays on PC 2 and the counter holds.
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t3_mem_req", mem_req, 1);
      check("t3_mem_addr", mem_addr, 2);
      check("t3_pc_load", pc_load, 1);
      check("t3_pc_load_val", pc_load_val, 2);
      check("t3_head_pc", instr_pc, 1);
      observe();
      advance();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t3_grant_addr", mem_addr, 2);
    check("t3_grant_no_load", pc_load, 0);
    observe();
    advance();
    repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Redirect while waiting for a response: stale response must be drained.
    do_reset();
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 26'h100);
    check("t4_redir_load", pc_load, 1);
    check("t4_redir_val", pc_load_val, 26'h100);
    check("t4_redir_mem_req", mem_req, 0);
    check("t4_redir_valid", instr_valid, 1);
    observe();
    advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t4_drain_mem_req", mem_req, 0);
    check("t4_drain_valid", instr_valid, 0);
    check("t4_drain_hold", pc_load_val, 26'h100);
    observe();
    advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t4_req_after_drain", mem_req, 1);
    check("t4_req_addr", mem_addr, 26'h100);
    check("t4_queue_empty", instr_valid, 0);
    observe();
    advance();
    wait_first_pc("t4_first_pc", 26'h100);

    // Redirect coinciding with a response and a pop: both are voided.
    do_reset();
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 26'h100);
    check("t5_rvalid_present", mem_rvalid, 1);
    check("t5_head_valid", instr_valid, 1);
    check("t5_redir_val", pc_load_val, 26'h100);
    observe();
    advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check("t5_queue_empty", instr_valid, 0);
    check("t5_mem_req", mem_req, 1);
    check("t5_mem_addr", mem_addr, 26'h100);
    observe();
    advance();
    wait_first_pc("t5_first_pc", 26'h100);

    // Random traffic against the architectural stream model.
    do_reset();
    acc_before = n_acc;
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0,
          ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 16'hffff))
                                      : ADDR_W'($urandom()));
    end
    check("rand_progress", (n_acc - acc_before) > 300, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
